// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite register bank with parallel export and per-register write pulses.
// Define AXIL_REG_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_WIDTH = 3,
   parameter int NUM_REGS   = 4,
   parameter int BASE_ADDR  = 0
) (
   input  logic                           s_axi_aclk,
   input  logic                           s_axi_areset,
   input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
   input  logic                           s_axi_awvalid,
   output logic                           s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
   input  logic [DATA_WIDTH/8:0]          s_axi_wstrb,
   input  logic                           s_axi_wvalid,
   output logic                           s_axi_wready,
   output logic [RESP_WIDTH-1:0]          s_axi_bresp,
   output logic                           s_axi_bvalid,
   input  logic                           s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
   input  logic                           s_axi_arvalid,
   output logic                           s_axi_arready,
   output logic [DATA_WIDTH-1:0]          s_axi_rdata,
   output logic [RESP_WIDTH-1:0]          s_axi_rresp,
   output logic                           s_axi_rvalid,
   input  logic                           s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);
   localparam int STRB = DATA_WIDTH/8;
   localparam int IW   = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
`ifdef AXIL_REG_SLAVE_SLVERR_EN
   localparam logic [RESP_WIDTH-1:0] MISS = RESP_WIDTH'(2);
`else
   localparam logic [RESP_WIDTH-1:0] MISS = '0;
`endif

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   w_state_e                w_state_q, w_state_d;
   r_state_e                r_state_q, r_state_d;
   logic                    aw_have_q, aw_have_d, w_have_q, w_have_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB-1:0]         wstrb_q, wstrb_d;
   logic                    awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
   logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [RESP_WIDTH-1:0]   bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]     pulse_q, pulse_d;
   logic [31:0]             w_off, r_off;
   logic                    w_hit, r_hit;
   logic [IW-1:0]           w_idx, r_idx;
   logic                    unused_strb;

   assign unused_strb = s_axi_wstrb[STRB];

   // Addresses below BASE_ADDR wrap to a huge offset and therefore miss.
   assign w_off = 32'(awaddr_q) - 32'(BASE_ADDR);
   assign r_off = 32'(s_axi_araddr) - 32'(BASE_ADDR);
   assign w_hit = w_off < 32'(4*NUM_REGS);
   assign r_hit = r_off < 32'(4*NUM_REGS);
   assign w_idx = w_off[IW+1:2];
   assign r_idx = r_off[IW+1:2];

   always_comb begin
      w_state_d = w_state_q;
      aw_have_d = aw_have_q;
      w_have_d  = w_have_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      regs_d    = regs_q;
      pulse_d   = '0;
      if (w_state_q == W_IDLE) begin
         if (aw_have_q && w_have_q) begin
            if (w_hit) begin
               for (int b = 0; b < STRB; b++)
                  if (wstrb_q[b]) regs_d[w_idx][b*8 +: 8] = wdata_q[b*8 +: 8];
               pulse_d[w_idx] = 1'b1;
            end
            bresp_d   = w_hit ? '0 : MISS;
            bvalid_d  = 1'b1;
            aw_have_d = 1'b0;
            w_have_d  = 1'b0;
            awready_d = 1'b0;
            wready_d  = 1'b0;
            w_state_d = W_RESP;
         end else begin
            if (s_axi_awvalid && awready_q) begin
               aw_have_d = 1'b1;
               awaddr_d  = s_axi_awaddr;
            end
            if (s_axi_wvalid && wready_q) begin
               w_have_d = 1'b1;
               wdata_d  = s_axi_wdata;
               wstrb_d  = s_axi_wstrb[STRB-1:0];
            end
            awready_d = !aw_have_d;
            wready_d  = !w_have_d;
         end
      end else if (s_axi_bready) begin
         bvalid_d  = 1'b0;
         awready_d = 1'b1;
         wready_d  = 1'b1;
         w_state_d = W_IDLE;
      end
   end

   // Reads sample regs_q, so a read on the commit edge sees the pre-write value.
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      if (r_state_q == R_IDLE) begin
         arready_d = 1'b1;
         if (s_axi_arvalid && arready_q) begin
            rdata_d   = r_hit ? regs_q[r_idx] : '0;
            rresp_d   = r_hit ? '0 : MISS;
            rvalid_d  = 1'b1;
            arready_d = 1'b0;
            r_state_d = R_DATA;
         end
      end else if (s_axi_rready) begin
         rvalid_d  = 1'b0;
         arready_d = 1'b1;
         r_state_d = R_IDLE;
      end
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         aw_have_q <= 1'b0;
         w_have_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         bresp_q   <= '0;
         rresp_q   <= '0;
         rdata_q   <= '0;
         regs_q    <= '{default: '0};
         pulse_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_have_q <= aw_have_d;
         w_have_q  <= w_have_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         arready_q <= arready_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         bresp_q   <= bresp_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         regs_q    <= regs_d;
         pulse_q   <= pulse_d;
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_arready = arready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign reg_wr_pulse  = pulse_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end
endmodule
